instr_fetch: RTL and testbench

Instruction fetch stage for the RV32 single-issue core. Holds the PC, issues one word-fetch at a time to instruction memory over a valid/ready request and valid response channel, and presents the fetched instruction with its PC to the decode/`control` stage through a valid/ready handshake. Taken-branch redirects from execute replace the PC and squash any in-flight or held instruction.

---
 rtl/instr_fetch.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32 instruction fetch stage.
// Holds the PC and keeps at most one word-fetch outstanding on the imem
// request/response channel. The fetched word and its PC are held for decode
// under a valid/ready handshake. A taken-branch redirect from execute replaces
// the PC and squashes any in-flight or held instruction.
//
// Optional feature macro: IFETCH_ALIGN_CHK_EN
//   defined   : a misaligned redirect target sets sticky fetch_err and halts fetch
//   undefined : redirect_pc[1:0] is forced to 00, fetch_err tied 0
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request (addr = pc), combinational
//   imem_rsp_valid, imem_rsp_data    one-cycle response pulse with fetched word
//   instr_valid/ready, instr,        registered instruction + PC to decode
//   instr_pc
//   redirect, redirect_pc            taken-branch pulse and target
//   fetch_err                        misaligned-target error (sticky)
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic              r_discard, w_discard_nxt;
  logic              r_instr_valid, w_instr_valid_nxt;
  logic [XLEN-1:0]   r_instr, w_instr_nxt;
  logic [XLEN-1:0]   r_instr_pc, w_instr_pc_nxt;

  logic              w_halt;
  logic              w_err_set;
  logic [XLEN-1:0]   w_redirect_tgt;

`ifdef IFETCH_ALIGN_CHK_EN
  logic r_fetch_err;

  // First misaligned redirect latches the error; fetch stays halted until rst.
  assign w_err_set      = redirect && !r_fetch_err && (redirect_pc[1:0] != 2'b00);
  assign w_halt         = r_fetch_err;
  assign w_redirect_tgt = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_err <= 1'b0;
    end else if (w_err_set) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_err_set      = 1'b0;
  assign w_halt         = 1'b0;
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_err      = 1'b0;
`endif

  // Request side is combinational from state/pc; suppressed during reset and halt.
  assign imem_req_valid = (r_state == S_REQ) && !rst && !w_halt;
  assign imem_addr      = r_pc;

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  // Next-state and next-output logic; redirect has priority over normal flow.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_discard_nxt     = r_discard;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;

    if (w_halt) begin
      // Halted: no requests, any late response is ignored.
      w_state_nxt       = S_REQ;
      w_discard_nxt     = 1'b0;
      w_instr_valid_nxt = 1'b0;
      w_instr_nxt       = NOP_INSTR;
    end else if (redirect) begin
      w_instr_valid_nxt = 1'b0;
      w_instr_nxt       = NOP_INSTR;
      if (w_err_set) begin
        w_state_nxt   = S_REQ;
        w_discard_nxt = 1'b0;
      end else begin
        w_pc_nxt = w_redirect_tgt;
        unique case (r_state)
          S_REQ: begin
            // An accepted request now belongs to the old path; drop its word.
            if (imem_req_ready) begin
              w_state_nxt   = S_WAIT;
              w_discard_nxt = 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              w_state_nxt   = S_REQ;
              w_discard_nxt = 1'b0;
            end else begin
              w_discard_nxt = 1'b1;
            end
          end
          S_HOLD: w_state_nxt = S_REQ;
          default: w_state_nxt = S_REQ;
        endcase
      end
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_req_ready) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = S_REQ;
            end else begin
              w_instr_nxt       = imem_rsp_data;
              w_instr_pc_nxt    = r_pc;
              w_instr_valid_nxt = 1'b1;
              w_pc_nxt          = r_pc + 32'd4;
              w_state_nxt       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = NOP_INSTR;
            w_state_nxt       = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_discard     <= w_discard_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: randomized memory/decode/redirect stimulus with a
// queue-based reference of the expected delivered instruction stream.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFETCH_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_err     (fetch_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_nxt = RESET_PC;
  bit          halted = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;

  // Stimulus knobs (percentages / max response delay).
  int p_ready = 100, p_iready = 100, max_dly = 0, p_spur = 0;
  bit rst_req = 1'b1;

  // Memory responder state.
  bit          pend = 1'b0;
  int          dly = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        prev_req_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          last_rsp_cycle = -10;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0080af03;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected stream: sequential PCs from the last redirect target / reset PC.
  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc   = model_nxt;
      e.data = mem_word(model_nxt);
      exp_q.push_back(e);
      model_nxt = model_nxt + 32'd4;
    end
  endtask

  task automatic model_redirect(input logic [31:0] t, input bit keep_front);
    exp_t f;
    if (keep_front && exp_q.size() > 0) begin
      f = exp_q[0];
      exp_q.delete();
      exp_q.push_back(f);
    end else begin
      exp_q.delete();
    end
    model_nxt = t;
    refill();
  endtask

  // One cycle of stimulus: drive inputs just after the edge, then sample requests.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit acc;
    @(posedge clk);
    #1;
    acc = prev_req_valid && prev_ready;
    rst = rst_req;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend = 1'b1;
      pend_addr = prev_addr;
      dly = $urandom_range(max_dly, 0);
    end
    if (rst_req) begin
      pend = 1'b0;
      halted = 1'b0;
      exp_q.delete();
      model_nxt = RESET_PC;
    end else if (pend) begin
      if (dly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 1'b0;
        last_rsp_cycle = cycle;
      end else begin
        dly--;
      end
    end else if ($urandom_range(99, 0) < p_spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = ($urandom_range(99, 0) < p_ready);
    instr_ready    = ($urandom_range(99, 0) < p_iready);
    redirect       = redir && !rst_req;
    redirect_pc    = tgt;
    if (redirect) begin
      if (ALIGN && tgt[1:0] != 2'b00) begin
        halted = 1'b1;
        exp_q.delete();
      end else begin
        model_redirect(tgt & 32'hFFFF_FFFC, instr_valid && instr_ready);
      end
    end
    if (!halted) refill();
    #1;
    prev_req_valid = imem_req_valid;
    prev_ready     = imem_req_ready;
    prev_addr      = imem_addr;
  endtask

  // Monitor: checks outputs at the falling edge and pops the scoreboard.
  logic        m_iv = 1'b0, m_consume = 1'b0, m_redir = 1'b0, m_rst = 1'b0;
  logic        m_rv = 1'b0, m_acc = 1'b0, m_halted = 1'b0;
  logic [31:0] m_instr = 32'h0, m_ipc = 32'h0, m_addr = 32'h0, m_tgt = 32'h0;
  int          idle_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("req_valid_in_reset", 32'(imem_req_valid), 32'h0);
        if (m_rst) begin
          check("rst_instr_valid", 32'(instr_valid), 32'h0);
          check("rst_instr", instr, NOP);
          check("rst_instr_pc", instr_pc, 32'h0);
          check("rst_fetch_err", 32'(fetch_err), 32'h0);
        end
        idle_cnt = 0;
      end else begin
        check("fetch_err", 32'(fetch_err), 32'(m_halted));
        if (m_iv && !m_consume && !m_redir && !m_rst) begin
          check("hold_valid", 32'(instr_valid), 32'h1);
          check("hold_instr", instr, m_instr);
          check("hold_instr_pc", instr_pc, m_ipc);
        end
        if (!instr_valid) check("idle_instr_nop", instr, NOP);
        if (instr_valid) check("no_req_while_holding", 32'(imem_req_valid), 32'h0);
        if (instr_valid && !m_iv) check("rsp_to_valid_latency", 32'(cycle), 32'(last_rsp_cycle + 1));
        if (m_rv && !m_acc && !m_redir && !m_rst) begin
          check("req_held_valid", 32'(imem_req_valid), 32'h1);
          check("req_held_addr", imem_addr, m_addr);
        end
        if (m_redir && imem_req_valid) check("redirect_addr", imem_addr, m_tgt);
        if (m_halted) begin
          check("halt_no_req", 32'(imem_req_valid), 32'h0);
          check("halt_no_instr", 32'(instr_valid), 32'h0);
        end
        if (instr_valid && instr_ready) begin
          idle_cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
          end
        end else if (!halted) begin
          idle_cnt++;
          if (idle_cnt > 400) begin
            check("watchdog_idle_cycles", 32'(idle_cnt), 32'h0);
            idle_cnt = 0;
          end
        end
      end
      m_iv      = instr_valid;
      m_instr   = instr;
      m_ipc     = instr_pc;
      m_consume = instr_valid && instr_ready && !rst;
      m_redir   = redirect && !rst;
      m_tgt     = redirect_pc & 32'hFFFF_FFFC;
      m_rst     = rst;
      m_rv      = imem_req_valid;
      m_acc     = imem_req_valid && imem_req_ready;
      m_addr    = imem_addr;
      m_halted  = halted;
    end
  end

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(3, 0) == 0) return 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
    return 32'($urandom_range(255, 0)) << 2;
  endfunction

  initial begin
    // Reset.
    rst_req = 1'b1;
    repeat (3) step(1'b0, 32'h0);
    rst_req = 1'b0;

    // Zero-wait memory, decode always ready.
    repeat (12) step(1'b0, 32'h0);

    // Decode stalls so the held instruction must stay stable.
    p_iready = 0;
    repeat (12) step(1'b0, 32'h0);
    p_iready = 100;
    repeat (4) step(1'b0, 32'h0);

    // Redirect while waiting on a slow response.
    max_dly = 2;
    for (int i = 0; i < 50; i++) begin
      if (pend && dly >= 1) begin
        step(1'b1, 32'h0000_0100);
        break;
      end
      step(1'b0, 32'h0);
    end
    repeat (10) step(1'b0, 32'h0);

    // Redirect in the same cycle the request is accepted.
    p_ready = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 32'h0);
      if (prev_req_valid) break;
    end
    p_ready = 100;
    step(1'b1, 32'h0000_0100);
    repeat (12) step(1'b0, 32'h0);

    // PC wrap past the top of the address space.
    step(1'b1, 32'hFFFF_FFF8);
    repeat (20) step(1'b0, 32'h0);

    // Randomized traffic with redirects and stray responses.
    p_ready = 70; p_iready = 70; max_dly = 3; p_spur = 10;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        rst_req = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        rst_req = 1'b0;
      end
      step($urandom_range(11, 0) == 0, rand_tgt());
    end

    // Misaligned redirect target.
    p_spur = 0;
    step(1'b1, 32'h0000_0102);
    repeat (20) step(1'b0, 32'h0);

    // Final reset clears everything, fetch resumes from the reset PC.
    rst_req = 1'b1;
    repeat (3) step(1'b0, 32'h0);
    rst_req = 1'b0;
    repeat (15) step(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
